// File: rtl/seg7_capture_decoder_if.sv
// Multiplexed 7-segment bus seen by the capture decoder, plus its decoded results.
// The master drives the display bus; the slave is the capture decoder.
interface seg7_capture_decoder_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] hex;
    logic [NDIG-1:0]   dig_valid;
    logic              pattern_err;
    logic              frame_done;

    modport master (output seg, an, input hex, dig_valid, pattern_err, frame_done);
    modport slave  (input seg, an, output hex, dig_valid, pattern_err, frame_done);
endinterface

// File: rtl/seg7_capture_decoder.sv
// Watches an active-low multiplexed 7-segment bus, waits for each digit pattern to
// settle, inverse-decodes it to hex and stores the value per digit position.

module seg7_digit_slot (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_val,
    output logic [3:0] hex,
    output logic       valid
);
    always_ff @(posedge clk) begin
        if (reset) begin
            hex   <= '0;
            valid <= 1'b0;
        end else if (wr_en) begin
            hex   <= wr_val;
            valid <= 1'b1;
        end
    end
endmodule

module seg7_capture_decoder #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    seg7_capture_decoder_if.slave  bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD} state_t;

    state_t            state, state_n;
    logic [NDIG-1:0]   an_s, ref_an, ref_an_n, acc_an;
    logic [6:0]        seg_s, ref_seg, ref_seg_n, acc_seg;
    logic [CW-1:0]     cnt, cnt_n;
    logic              single, same, accept, load, acc_vld;
    logic [4:0]        dec;
    logic [NDIG-1:0]   wr_bits, mask, valid_q;
    logic [NDIG-1:0][3:0] hex_q;
    logic              err_q, frame_q;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40: decode = 5'h10;  7'h79: decode = 5'h11;
            7'h24: decode = 5'h12;  7'h30: decode = 5'h13;
            7'h19: decode = 5'h14;  7'h12: decode = 5'h15;
            7'h02: decode = 5'h16;  7'h78: decode = 5'h17;
            7'h00: decode = 5'h18;  7'h18: decode = 5'h19;
            7'h08: decode = 5'h1A;  7'h03: decode = 5'h1B;
            7'h46: decode = 5'h1C;  7'h21: decode = 5'h1D;
            7'h06: decode = 5'h1E;  7'h0E: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    // Sample stage resets to an idle bus so a count always restarts cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_s  <= '1;
            seg_s <= '1;
        end else begin
            an_s  <= bus.an;
            seg_s <= bus.seg;
        end
    end

    assign single = $onehot(~an_s);
    assign same   = (an_s == ref_an) && (seg_s == ref_seg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ref_an  <= '1;
            ref_seg <= '1;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            ref_an  <= ref_an_n;
            ref_seg <= ref_seg_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        ref_an_n  = ref_an;
        ref_seg_n = ref_seg;
        cnt_n     = cnt;
        accept    = 1'b0;
        load      = 1'b0;
        case (state)
            S_IDLE:  load = single;
            S_COUNT: begin
                if (same) begin
                    cnt_n = cnt + CW'(1);
                    if (cnt_n == CW'(STABLE_CYCLES)) begin
                        accept  = 1'b1;
                        state_n = S_HOLD;
                    end
                end else if (single) load = 1'b1;
                else state_n = S_IDLE;
            end
            S_HOLD: begin
                if (!same) begin
                    if (single) load = 1'b1;
                    else state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // A new reference always starts a run of one; a one-sample threshold accepts it at once.
        if (load) begin
            ref_an_n  = an_s;
            ref_seg_n = seg_s;
            cnt_n     = CW'(1);
            if (STABLE_CYCLES == 1) begin
                accept  = 1'b1;
                state_n = S_HOLD;
            end else begin
                state_n = S_COUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_vld <= 1'b0;
            acc_an  <= '1;
            acc_seg <= '1;
        end else begin
            acc_vld <= accept;
            acc_an  <= an_s;
            acc_seg <= seg_s;
        end
    end

    assign dec     = decode(acc_seg);
    assign wr_bits = {NDIG{acc_vld & dec[4]}} & ~acc_an;

    for (genvar i = 0; i < NDIG; i++) begin : g_slot
        seg7_digit_slot u_slot (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (wr_bits[i]),
            .wr_val (dec[3:0]),
            .hex    (hex_q[i]),
            .valid  (valid_q[i])
        );
    end

    // The completing write raises frame_done and starts an empty mask for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask    <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (acc_vld && !dec[4]) err_q <= 1'b1;
            if ((mask | wr_bits) == '1) begin
                frame_q <= 1'b1;
                mask    <= '0;
            end else begin
                mask    <= mask | wr_bits;
            end
        end
    end

    assign bus.hex         = hex_q;
    assign bus.dig_valid   = valid_q;
    assign bus.pattern_err = err_q;
    assign bus.frame_done  = frame_q;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: directed scenarios plus random bus traffic against
// a run-length reference model of the capture rules.
module tb_seg7_capture_decoder;
    localparam int NDIG = 4;
    localparam int ST   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_capture_decoder_if #(.NDIG(NDIG)) bus ();

    seg7_capture_decoder #(.NDIG(NDIG), .STABLE_CYCLES(ST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a pattern is accepted when the sampled bus has shown the same
    // single-anode pattern for exactly ST consecutive samples; the write lands one later.
    logic [NDIG-1:0]   m_an;
    logic [6:0]        m_seg;
    int                m_run;
    logic              m_pend;
    logic [NDIG-1:0]   m_pend_an;
    logic [6:0]        m_pend_seg;
    logic [NDIG-1:0]   m_mask;
    logic [4*NDIG-1:0] exp_hex;
    logic [NDIG-1:0]   exp_valid;
    logic              exp_err, exp_frame;

    task automatic model_step();
        int v, d;
        if (reset) begin
            m_an = '1; m_seg = '1; m_run = 0; m_pend = 0; m_mask = '0;
            exp_hex = '0; exp_valid = '0; exp_err = 0; exp_frame = 0;
            return;
        end
        exp_frame = 0;
        if (m_pend) begin
            v = -1; d = 0;
            for (int k = 0; k < 16; k++) if (tbl[k] == m_pend_seg) v = k;
            for (int k = 0; k < NDIG; k++) if (!m_pend_an[k]) d = k;
            if (v < 0) exp_err = 1;
            else begin
                exp_hex[4*d +: 4] = 4'(v);
                exp_valid[d] = 1;
                m_mask[d] = 1;
                if (m_mask == '1) begin exp_frame = 1; m_mask = '0; end
            end
        end
        m_pend = ($countones(~m_an) == 1) && (m_run == ST);
        m_pend_an = m_an; m_pend_seg = m_seg;
        if (bus.an == m_an && bus.seg == m_seg) m_run = (m_run > ST) ? m_run : m_run + 1;
        else m_run = 1;
        m_an = bus.an; m_seg = bus.seg;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [NDIG-1:0] an, input logic [6:0] seg, input int n);
        bus.an = an; bus.seg = seg;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1; bus.an = '1; bus.seg = '1;
        tick(); tick();
        n_cmp++; if (bus.hex !== '0) begin n_bad++; $display("FAIL reset_hex got %h want 0", bus.hex); end
        n_cmp++; if (bus.dig_valid !== '0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.dig_valid); end
        n_cmp++; if (bus.pattern_err !== 1'b0 || bus.frame_done !== 1'b0)
            begin n_bad++; $display("FAIL reset_flags got err=%b frame=%b want 0 0", bus.pattern_err, bus.frame_done); end
        reset = 0;
        drive('1, '1, 2);
    endtask

    task automatic test_single_capture();
        bus.an = 4'b1110; bus.seg = 7'h30;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 5) begin
                n_cmp++; if (bus.dig_valid !== 4'b0000) begin n_bad++; $display("FAIL early_capture got %b want 0000", bus.dig_valid); end
            end
            if (c == 6) begin
                n_cmp++; if (bus.hex[3:0] !== 4'h3 || bus.dig_valid !== 4'b0001)
                    begin n_bad++; $display("FAIL latency6 got hex=%h valid=%b want 3 0001", bus.hex[3:0], bus.dig_valid); end
            end
            n_cmp++; if (bus.hex !== exp_hex || bus.dig_valid !== exp_valid || bus.frame_done !== exp_frame)
                begin n_bad++; $display("FAIL single_hold c=%0d got %h/%b/%b want %h/%b/%b", c, bus.hex, bus.dig_valid, bus.frame_done, exp_hex, exp_valid, exp_frame); end
        end
    endtask

    task automatic test_scan();
        logic [6:0] pats [4] = '{7'h79, 7'h24, 7'h0E, 7'h40};
        int pulses = 0;
        for (int d = 0; d < 4; d++) begin
            bus.an = ~(4'b0001 << d); bus.seg = pats[d];
            for (int c = 0; c < 5; c++) begin
                tick();
                pulses += int'(bus.frame_done);
                n_cmp++; if (bus.frame_done !== exp_frame || bus.hex !== exp_hex)
                    begin n_bad++; $display("FAIL scan d=%0d got frame=%b hex=%h want %b %h", d, bus.frame_done, bus.hex, exp_frame, exp_hex); end
            end
        end
        bus.an = '1; bus.seg = '1;
        repeat (3) begin tick(); pulses += int'(bus.frame_done); end
        n_cmp++; if (bus.hex !== 16'h0F21 || bus.dig_valid !== 4'b1111)
            begin n_bad++; $display("FAIL scan_result got %h/%b want 0f21/1111", bus.hex, bus.dig_valid); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL scan_pulses got %0d want 1", pulses); end
        // Mask must be empty now: one more capture cannot complete a frame.
        bus.an = 4'b1110; bus.seg = 7'h24;
        repeat (8) begin tick(); pulses += int'(bus.frame_done); end
        n_cmp++; if (pulses !== 1 || bus.hex[3:0] !== 4'h2)
            begin n_bad++; $display("FAIL mask_clear got pulses=%0d hex0=%h want 1 2", pulses, bus.hex[3:0]); end
    endtask

    task automatic test_glitch();
        logic [4*NDIG-1:0] snap_hex;
        logic [NDIG-1:0]   snap_valid;
        int a, b;
        drive('1, '1, 4);
        snap_hex = exp_hex; snap_valid = exp_valid;
        a = $urandom_range(0, 15); b = (a + $urandom_range(1, 15)) % 16;
        for (int k = 0; k < 8; k++) drive(4'b1101, tbl[(k % 2) ? b : a], 3);
        drive('1, '1, 3);
        n_cmp++; if (bus.hex !== snap_hex || bus.dig_valid !== snap_valid)
            begin n_bad++; $display("FAIL glitch got %h/%b want %h/%b", bus.hex, bus.dig_valid, snap_hex, snap_valid); end
    endtask

    task automatic test_multi_anode();
        logic [4*NDIG-1:0] snap_hex;
        drive('1, '1, 4);
        snap_hex = exp_hex;
        drive(4'b1100, 7'h00, 20);
        n_cmp++; if (bus.hex !== snap_hex) begin n_bad++; $display("FAIL multi_anode got %h want %h", bus.hex, snap_hex); end
        drive(4'b1011, 7'h00, 6);
        n_cmp++; if (bus.hex[11:8] !== 4'h8 || bus.dig_valid[2] !== 1'b1)
            begin n_bad++; $display("FAIL digit2_capture got %h/%b want 8/1", bus.hex[11:8], bus.dig_valid[2]); end
    endtask

    task automatic test_illegal();
        logic [3:0] snap_d3;
        logic       snap_v3;
        int v;
        drive('1, '1, 4);
        snap_d3 = exp_hex[15:12]; snap_v3 = exp_valid[3];
        drive(4'b0111, 7'h7F, 6);
        n_cmp++; if (bus.pattern_err !== 1'b1) begin n_bad++; $display("FAIL illegal_err got %b want 1", bus.pattern_err); end
        n_cmp++; if (bus.hex[15:12] !== snap_d3 || bus.dig_valid[3] !== snap_v3)
            begin n_bad++; $display("FAIL illegal_nowrite got %h/%b want %h/%b", bus.hex[15:12], bus.dig_valid[3], snap_d3, snap_v3); end
        v = $urandom_range(0, 15);
        drive(4'b1110, 7'h7F, 1);
        drive(4'b0111, tbl[v], 6);
        n_cmp++; if (bus.pattern_err !== 1'b1 || bus.hex[15:12] !== 4'(v))
            begin n_bad++; $display("FAIL err_sticky got err=%b hex3=%h want 1 %h", bus.pattern_err, bus.hex[15:12], 4'(v)); end
    endtask

    task automatic test_reset_mid();
        drive('1, '1, 4);
        drive(4'b1110, 7'h19, 4);
        reset = 1; tick(); reset = 0;
        n_cmp++; if (bus.hex !== '0 || bus.dig_valid !== '0 || bus.pattern_err !== 1'b0 || bus.frame_done !== 1'b0)
            begin n_bad++; $display("FAIL reset_mid got %h/%b/%b/%b want all 0", bus.hex, bus.dig_valid, bus.pattern_err, bus.frame_done); end
        drive(4'b1110, 7'h19, 5);
        n_cmp++; if (bus.dig_valid !== 4'b0000) begin n_bad++; $display("FAIL partial_kept got %b want 0000", bus.dig_valid); end
        tick();
        n_cmp++; if (bus.hex !== 16'h0004 || bus.dig_valid !== 4'b0001)
            begin n_bad++; $display("FAIL fresh_capture got %h/%b want 0004/0001", bus.hex, bus.dig_valid); end
    endtask

    task automatic test_random();
        logic [NDIG-1:0] an;
        logic [6:0]      seg;
        for (int k = 0; k < 60; k++) begin
            an  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ~(4'b0001 << $urandom_range(0, 3));
            seg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 15)];
            bus.an = an; bus.seg = seg;
            for (int c = $urandom_range(1, 8); c > 0; c--) begin
                tick();
                n_cmp++; if (bus.hex !== exp_hex || bus.dig_valid !== exp_valid ||
                             bus.pattern_err !== exp_err || bus.frame_done !== exp_frame)
                    begin n_bad++; $display("FAIL random k=%0d got %h/%b/%b/%b want %h/%b/%b/%b", k, bus.hex, bus.dig_valid,
                        bus.pattern_err, bus.frame_done, exp_hex, exp_valid, exp_err, exp_frame); end
            end
        end
    endtask

    initial begin
        reset = 1; bus.an = '1; bus.seg = '1;
        test_reset();
        test_single_capture();
        test_scan();
        test_glitch();
        test_multi_anode();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
